// File: rtl/lift_scheduler_pkg.sv
// Shared types for the lift scheduler: FSM state and travel direction
// encodings plus the floor-index width helper.
package lift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Width of a floor index; never less than one bit.
    function automatic int floor_width(input int n_floors);
        return (n_floors <= 2) ? 1 : $clog2(n_floors);
    endfunction

endpackage

// File: rtl/lift_scheduler_if.sv
// Call-button / car-status bundle between the lift scheduler and its
// surroundings. The scheduler uses the slave view.
interface lift_scheduler_if
    import lift_pkg::*;
#(
    parameter int N_FLOORS = 4
);
    localparam int FW = floor_width(N_FLOORS);

    logic [N_FLOORS-1:0] req_btn;
    logic [FW-1:0]       floor;
    logic                moving_up;
    logic                moving_down;
    logic                door_open;
    logic                arrived;
    logic [N_FLOORS-1:0] pending;

    modport master (
        output req_btn,
        input  floor, moving_up, moving_down, door_open, arrived, pending
    );

    modport slave (
        input  req_btn,
        output floor, moving_up, moving_down, door_open, arrived, pending
    );

endinterface

// File: rtl/lift_scheduler_req_register.sv
// Per-floor call latch: edge-detects raw buttons, holds outstanding calls,
// and reports whether any call lies above or below the car.
module lift_req_register
    import lift_pkg::*;
#(
    parameter int N_FLOORS = 4,
    parameter int FW       = floor_width(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] req_btn,
    input  logic [FW-1:0]       floor,
    input  logic                suppress_here,
    input  logic                clr_en,
    input  logic [FW-1:0]       clr_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                rise_here,
    output logic                any_above,
    output logic                any_below
);

    logic [N_FLOORS-1:0] btn_d_r;
    logic [N_FLOORS-1:0] pending_r;
    logic [N_FLOORS-1:0] rise_s;
    logic [N_FLOORS-1:0] here_mask_s;
    logic [N_FLOORS-1:0] clr_mask_s;
    logic [N_FLOORS-1:0] set_mask_s;
    logic [N_FLOORS-1:0] above_mask_s;
    logic [N_FLOORS-1:0] below_mask_s;
    logic [N_FLOORS-1:0] pending_next_s;

    // Rising edges, floor masks and next pending set (clear beats set).
    always_comb begin
        rise_s       = req_btn & ~btn_d_r;
        here_mask_s  = {N_FLOORS{1'b0}};
        clr_mask_s   = {N_FLOORS{1'b0}};
        above_mask_s = {N_FLOORS{1'b0}};
        below_mask_s = {N_FLOORS{1'b0}};
        for (int i = 0; i < N_FLOORS; i++) begin
            here_mask_s[i]  = (FW'(i) == floor);
            clr_mask_s[i]   = clr_en & (FW'(i) == clr_floor);
            above_mask_s[i] = (FW'(i) > floor);
            below_mask_s[i] = (FW'(i) < floor);
        end
        if (suppress_here) begin
            set_mask_s = rise_s & ~here_mask_s;
        end else begin
            set_mask_s = rise_s;
        end
        pending_next_s = (pending_r | set_mask_s) & ~clr_mask_s;
    end

    assign pending   = pending_r;
    assign rise_here = |(rise_s & here_mask_s);
    assign any_above = |(pending_r & above_mask_s);
    assign any_below = |(pending_r & below_mask_s);

    // Button history and pending-call register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_d_r   <= {N_FLOORS{1'b0}};
            pending_r <= {N_FLOORS{1'b0}};
        end else begin
            btn_d_r   <= req_btn;
            pending_r <= pending_next_s;
        end
    end

endmodule

// File: rtl/lift_scheduler.sv
// Car-motion scheduler: collective (SCAN) policy over latched floor calls,
// with per-floor travel timing and door dwell timing.
module lift_scheduler
    import lift_pkg::*;
#(
    parameter int N_FLOORS    = 4,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    lift_scheduler_if.slave  bus
);

    localparam int FW = floor_width(N_FLOORS);
    localparam int MW = $clog2(MOVE_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

    state_t        state_r, state_next_s;
    dir_t          dir_r, dir_next_s;
    logic [FW-1:0] floor_r, floor_next_s;
    logic [MW-1:0] move_cnt_r, move_cnt_next_s;
    logic [DW-1:0] door_cnt_r, door_cnt_next_s;
    logic          arrived_r, arrived_next_s;
    logic          moving_up_r, moving_down_r, door_open_r;
    logic          clr_en_s;
    logic          suppress_here_s;
    logic          ahead_s, behind_s;
    logic [N_FLOORS-1:0] pending_s;
    logic          rise_here_s, any_above_s, any_below_s;

    // A call at the car's own floor is never latched while the car is parked.
    assign suppress_here_s = (state_r == ST_IDLE) || (state_r == ST_DOOR_OPEN);

    lift_req_register #(
        .N_FLOORS (N_FLOORS),
        .FW       (FW)
    ) u_req (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_btn       (bus.req_btn),
        .floor         (floor_r),
        .suppress_here (suppress_here_s),
        .clr_en        (clr_en_s),
        .clr_floor     (floor_next_s),
        .pending       (pending_s),
        .rise_here     (rise_here_s),
        .any_above     (any_above_s),
        .any_below     (any_below_s)
    );

    // Next-state, counter, floor and arrival decisions for the SCAN policy.
    always_comb begin
        state_next_s    = state_r;
        dir_next_s      = dir_r;
        floor_next_s    = floor_r;
        move_cnt_next_s = move_cnt_r;
        door_cnt_next_s = door_cnt_r;
        arrived_next_s  = 1'b0;
        clr_en_s        = 1'b0;
        ahead_s         = (dir_r == DIR_UP) ? any_above_s : any_below_s;
        behind_s        = (dir_r == DIR_UP) ? any_below_s : any_above_s;
        case (state_r)
            ST_IDLE: begin
                if (rise_here_s) begin
                    state_next_s    = ST_DOOR_OPEN;
                    door_cnt_next_s = {DW{1'b0}};
                    arrived_next_s  = 1'b1;
                end else if (any_above_s) begin
                    state_next_s    = ST_MOVE_UP;
                    dir_next_s      = DIR_UP;
                    move_cnt_next_s = {MW{1'b0}};
                end else if (any_below_s) begin
                    state_next_s    = ST_MOVE_DOWN;
                    dir_next_s      = DIR_DOWN;
                    move_cnt_next_s = {MW{1'b0}};
                end else begin
                    state_next_s    = ST_IDLE;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (move_cnt_r == MOVE_LAST) begin
                    if (state_r == ST_MOVE_UP) begin
                        floor_next_s = floor_r + FW'(1'b1);
                    end else begin
                        floor_next_s = floor_r - FW'(1'b1);
                    end
                    move_cnt_next_s = {MW{1'b0}};
                    if (pending_s[floor_next_s]) begin
                        clr_en_s        = 1'b1;
                        state_next_s    = ST_DOOR_OPEN;
                        door_cnt_next_s = {DW{1'b0}};
                        arrived_next_s  = 1'b1;
                    end else begin
                        state_next_s    = state_r;
                    end
                end else begin
                    move_cnt_next_s = move_cnt_r + MW'(1'b1);
                end
            end
            ST_DOOR_OPEN: begin
                if (rise_here_s) begin
                    door_cnt_next_s = {DW{1'b0}};
                end else if (door_cnt_r == DOOR_LAST) begin
                    move_cnt_next_s = {MW{1'b0}};
                    if (ahead_s) begin
                        state_next_s = (dir_r == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
                    end else if (behind_s) begin
                        dir_next_s   = (dir_r == DIR_UP) ? DIR_DOWN : DIR_UP;
                        state_next_s = (dir_r == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    door_cnt_next_s = door_cnt_r + DW'(1'b1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, direction, floor, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            dir_r         <= DIR_UP;
            floor_r       <= {FW{1'b0}};
            move_cnt_r    <= {MW{1'b0}};
            door_cnt_r    <= {DW{1'b0}};
            arrived_r     <= 1'b0;
            moving_up_r   <= 1'b0;
            moving_down_r <= 1'b0;
            door_open_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            dir_r         <= dir_next_s;
            floor_r       <= floor_next_s;
            move_cnt_r    <= move_cnt_next_s;
            door_cnt_r    <= door_cnt_next_s;
            arrived_r     <= arrived_next_s;
            moving_up_r   <= (state_next_s == ST_MOVE_UP);
            moving_down_r <= (state_next_s == ST_MOVE_DOWN);
            door_open_r   <= (state_next_s == ST_DOOR_OPEN);
        end
    end

    assign bus.floor       = floor_r;
    assign bus.moving_up   = moving_up_r;
    assign bus.moving_down = moving_down_r;
    assign bus.door_open   = door_open_r;
    assign bus.arrived     = arrived_r;
    assign bus.pending     = pending_s;

endmodule

// File: tb/tb_lift_scheduler.sv
// Self-checking bench for lift_scheduler: directed scenarios plus random
// button traffic, compared each cycle against a countdown-timer car model.
module tb_lift_scheduler;

    localparam int NF = 4;
    localparam int MC = 4;
    localparam int DC = 3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    lift_scheduler_if #(.N_FLOORS(NF)) bus ();

    lift_scheduler #(
        .N_FLOORS    (NF),
        .MOVE_CYCLES (MC),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference car: mode 0 parked, 1 going up, 2 going down, 3 door open.
    int       m_mode;
    int       m_floor;
    int       m_dir;
    int       m_timer;
    bit       m_arr;
    bit [3:0] m_pend;
    bit [3:0] m_prev;

    task automatic model_step(input logic rst, input logic [3:0] btn);
        bit [3:0] rise;
        bit [3:0] p;
        bit       any_up, any_dn, ahead, behind, served;
        int       old_floor, old_mode, served_floor;
        if (!rst) begin
            m_mode = 0; m_floor = 0; m_dir = 1; m_timer = 0;
            m_arr = 1'b0; m_pend = 4'b0000; m_prev = 4'b0000;
            return;
        end
        rise = btn & ~m_prev;
        m_prev = btn;
        p = m_pend;
        old_floor = m_floor;
        old_mode = m_mode;
        m_arr = 1'b0;
        served = 1'b0;
        served_floor = 0;
        any_up = 1'b0;
        any_dn = 1'b0;
        for (int f = 0; f < NF; f++) begin
            if (p[f] && f > m_floor) any_up = 1'b1;
            if (p[f] && f < m_floor) any_dn = 1'b1;
        end
        case (m_mode)
            0: begin
                if (rise[m_floor]) begin
                    m_mode = 3; m_timer = DC; m_arr = 1'b1;
                end else if (any_up) begin
                    m_mode = 1; m_dir = 1; m_timer = MC;
                end else if (any_dn) begin
                    m_mode = 2; m_dir = -1; m_timer = MC;
                end
            end
            1, 2: begin
                m_timer--;
                if (m_timer == 0) begin
                    m_floor += (m_mode == 1) ? 1 : -1;
                    if (m_floor >= 0 && m_floor < NF && p[m_floor]) begin
                        served = 1'b1; served_floor = m_floor;
                        m_mode = 3; m_timer = DC; m_arr = 1'b1;
                    end else begin
                        m_timer = MC;
                    end
                end
            end
            default: begin
                if (rise[m_floor]) begin
                    m_timer = DC;
                end else begin
                    m_timer--;
                    if (m_timer == 0) begin
                        ahead  = (m_dir > 0) ? any_up : any_dn;
                        behind = (m_dir > 0) ? any_dn : any_up;
                        if (ahead) begin
                            m_mode = (m_dir > 0) ? 1 : 2; m_timer = MC;
                        end else if (behind) begin
                            m_dir = -m_dir;
                            m_mode = (m_dir > 0) ? 1 : 2; m_timer = MC;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end
            end
        endcase
        for (int i = 0; i < NF; i++) begin
            if (rise[i] && !((old_mode == 0 || old_mode == 3) && i == old_floor)
                && !(served && i == served_floor)) m_pend[i] = 1'b1;
        end
        if (served) m_pend[served_floor] = 1'b0;
    endtask

    function automatic logic [9:0] model_outs();
        return {m_floor[1:0], (m_mode == 1), (m_mode == 2), (m_mode == 3), m_arr, m_pend};
    endfunction

    function automatic logic [9:0] dut_outs();
        return {bus.floor, bus.moving_up, bus.moving_down, bus.door_open, bus.arrived, bus.pending};
    endfunction

    task automatic tick(input logic rst, input logic [3:0] btn);
        rst_n = rst;
        bus.req_btn = btn;
        @(posedge clk);
        model_step(rst, btn);
        #1;
    endtask

    // Car must never travel up from the top floor or down from the ground floor.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            total++;
            if ((bus.moving_up === 1'b1 && bus.floor === 2'd3) ||
                (bus.moving_down === 1'b1 && bus.floor === 2'd0)) begin
                $display("FAIL bounds floor=%0d up=%b down=%b required in-range travel",
                         bus.floor, bus.moving_up, bus.moving_down);
                bad++;
            end
        end
    end

    task automatic test_reset();
        tick(1'b0, 4'b0000);
        tick(1'b0, 4'b0000);
        total++;
        if (dut_outs() !== 10'd0) begin
            $display("FAIL reset_init got=%b exp=%b", dut_outs(), 10'd0); bad++;
        end
        tick(1'b1, 4'b0001);
        total++;
        if (bus.door_open !== 1'b1 || bus.arrived !== 1'b1) begin
            $display("FAIL reset_door_setup got door=%b arr=%b exp 1 1", bus.door_open, bus.arrived); bad++;
        end
        tick(1'b0, 4'b0000);
        tick(1'b0, 4'b0000);
        total++;
        if (dut_outs() !== 10'd0) begin
            $display("FAIL reset_mid_door got=%b exp=%b", dut_outs(), 10'd0); bad++;
        end
    endtask

    task automatic test_single_call();
        int up, arr, door;
        up = 0; arr = 0; door = 0;
        tick(1'b0, 4'b0000);
        tick(1'b1, 4'b0100);
        total++;
        if (bus.pending !== 4'b0100) begin
            $display("FAIL single_latch got=%b exp=%b", bus.pending, 4'b0100); bad++;
        end
        for (int c = 0; c < 20; c++) begin
            tick(1'b1, 4'b0000);
            total++;
            if (dut_outs() !== model_outs()) begin
                $display("FAIL single_model cyc=%0d got=%b exp=%b", c, dut_outs(), model_outs()); bad++;
            end
            up += int'(bus.moving_up); arr += int'(bus.arrived); door += int'(bus.door_open);
        end
        total++;
        if (up !== 8 || arr !== 1 || door !== 3) begin
            $display("FAIL single_counts got up=%0d arr=%0d door=%0d exp 8 1 3", up, arr, door); bad++;
        end
        total++;
        if (dut_outs() !== {2'd2, 8'b0}) begin
            $display("FAIL single_final got=%b exp=%b", dut_outs(), {2'd2, 8'b0}); bad++;
        end
    endtask

    task automatic test_held_button();
        int arr;
        arr = 0;
        tick(1'b0, 4'b0000);
        for (int c = 0; c < 30; c++) begin
            tick(1'b1, 4'b1000);
            total++;
            if (dut_outs() !== model_outs()) begin
                $display("FAIL held_model cyc=%0d got=%b exp=%b", c, dut_outs(), model_outs()); bad++;
            end
            arr += int'(bus.arrived);
        end
        total++;
        if (arr !== 1 || bus.floor !== 2'd3 || bus.pending !== 4'b0000) begin
            $display("FAIL held_once got arr=%0d floor=%0d pend=%b exp 1 3 0000", arr, bus.floor, bus.pending); bad++;
        end
        tick(1'b1, 4'b0000);
        tick(1'b1, 4'b0000);
        tick(1'b1, 4'b1000);
        total++;
        if (bus.door_open !== 1'b1 || bus.arrived !== 1'b1 || bus.pending !== 4'b0000) begin
            $display("FAIL held_repress got door=%b arr=%b pend=%b exp 1 1 0000",
                     bus.door_open, bus.arrived, bus.pending); bad++;
        end
        for (int c = 0; c < 5; c++) begin
            tick(1'b1, 4'b0000);
            total++;
            if (dut_outs() !== model_outs()) begin
                $display("FAIL held_close cyc=%0d got=%b exp=%b", c, dut_outs(), model_outs()); bad++;
            end
        end
    endtask

    task automatic test_intermediate_stop();
        int arr, door, first_floor;
        arr = 0; door = 0; first_floor = -1;
        tick(1'b0, 4'b0000);
        tick(1'b1, 4'b1000);
        tick(1'b1, 4'b0000);
        tick(1'b1, 4'b0010);
        for (int c = 0; c < 30; c++) begin
            tick(1'b1, 4'b0000);
            total++;
            if (dut_outs() !== model_outs()) begin
                $display("FAIL stop_model cyc=%0d got=%b exp=%b", c, dut_outs(), model_outs()); bad++;
            end
            if (bus.arrived === 1'b1 && first_floor < 0) first_floor = int'(bus.floor);
            arr += int'(bus.arrived); door += int'(bus.door_open);
        end
        total++;
        if (first_floor !== 1 || arr !== 2 || door !== 6 || bus.floor !== 2'd3) begin
            $display("FAIL stop_summary got first=%0d arr=%0d door=%0d floor=%0d exp 1 2 6 3",
                     first_floor, arr, door, bus.floor); bad++;
        end
    endtask

    task automatic test_reverse();
        int down;
        bit seen;
        down = 0; seen = 1'b0;
        tick(1'b0, 4'b0000);
        tick(1'b1, 4'b0100);
        for (int c = 0; c < 20 && !seen; c++) begin
            tick(1'b1, 4'b0000);
            if (bus.door_open === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            $display("FAIL reverse_timeout door_open never seen, required 1"); bad++;
        end
        tick(1'b1, 4'b0001);
        total++;
        if (bus.pending !== 4'b0001 || bus.floor !== 2'd2) begin
            $display("FAIL reverse_latch got pend=%b floor=%0d exp 0001 2", bus.pending, bus.floor); bad++;
        end
        for (int c = 0; c < 20; c++) begin
            tick(1'b1, 4'b0000);
            total++;
            if (dut_outs() !== model_outs()) begin
                $display("FAIL reverse_model cyc=%0d got=%b exp=%b", c, dut_outs(), model_outs()); bad++;
            end
            down += int'(bus.moving_down);
        end
        total++;
        if (down !== 8 || bus.floor !== 2'd0 || bus.pending !== 4'b0000) begin
            $display("FAIL reverse_counts got down=%0d floor=%0d pend=%b exp 8 0 0000",
                     down, bus.floor, bus.pending); bad++;
        end
    endtask

    task automatic test_reset_mid_move();
        tick(1'b0, 4'b0000);
        tick(1'b0, 4'b0000);
        tick(1'b1, 4'b1010);
        tick(1'b1, 4'b0000);
        tick(1'b1, 4'b0000);
        tick(1'b1, 4'b0000);
        total++;
        if (bus.moving_up !== 1'b1 || bus.pending !== 4'b1010) begin
            $display("FAIL midmove_setup got up=%b pend=%b exp 1 1010", bus.moving_up, bus.pending); bad++;
        end
        tick(1'b0, 4'b0000);
        total++;
        if (dut_outs() !== 10'd0) begin
            $display("FAIL midmove_reset got=%b exp=%b", dut_outs(), 10'd0); bad++;
        end
    endtask

    task automatic test_random();
        logic [3:0] btn;
        logic       rst;
        btn = 4'b0000;
        tick(1'b0, 4'b0000);
        tick(1'b0, 4'b0000);
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) btn[$urandom_range(0, 3)] = ~btn[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) btn = 4'b0000;
            rst = ($urandom_range(0, 399) != 0);
            tick(rst, btn);
            total++;
            if (dut_outs() !== model_outs()) begin
                $display("FAIL random_model cyc=%0d btn=%b got=%b exp=%b", c, btn, dut_outs(), model_outs()); bad++;
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.req_btn = 4'b0000;
        model_step(1'b0, 4'b0000);
        test_reset();
        test_single_call();
        test_held_button();
        test_intermediate_stop();
        test_reverse();
        test_reset_mid_move();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
